sseg_scan_driver: RTL and testbench

- Multiplexed common-anode driver for NUM_DIGITS hexadecimal digits with a decimal point per digit, sharing one 8-bit segment bus.
- Time-division scans one digit per SCAN_DIV clocks.
- Display data is double-buffered: a new value is applied only at a frame boundary, so a frame never shows a mix of old and new digits.
- Sits between board-level display pins and any logic that produces hex values.

---
 rtl/sseg_scan_driver.sv | 166 ++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// Multiplexed common-anode hex display driver with a frame-boundary double buffer.
// Define SSEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module sseg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] HexIn,
  input  logic [NUM_DIGITS-1:0]   DPIn,
  input  logic [NUM_DIGITS-1:0]   DigitEn,
  input  logic                    Load,
  output logic [7:0]              SSeg,
  output logic [NUM_DIGITS-1:0]   Anode,
  output logic                    FrameTick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = 6 * NUM_DIGITS;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  // Segment pattern A..G, active-low
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0:    glyph = 7'h01;
      4'h1:    glyph = 7'h4F;
      4'h2:    glyph = 7'h12;
      4'h3:    glyph = 7'h06;
      4'h4:    glyph = 7'h4C;
      4'h5:    glyph = 7'h24;
      4'h6:    glyph = 7'h20;
      4'h7:    glyph = 7'h0F;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h04;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h60;
      4'hC:    glyph = 7'h31;
      4'hD:    glyph = 7'h42;
      4'hE:    glyph = 7'h30;
      default: glyph = 7'h38;
    endcase
  endfunction

  logic [PW-1:0]         prescaler_reg, prescaler_next;
  logic [IW-1:0]         digit_idx_reg, digit_idx_next;
  logic                  adv, wrap;

  logic [BW-1:0]         shadow_reg, shadow_next;
  logic [BW-1:0]         active_reg, active_next;
  logic                  pending_reg, pending_next;
  logic [BW-1:0]         port_word;

  logic [4*NUM_DIGITS-1:0] act_hex;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_en;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   show;
  logic [6:0]              glyph_arr [NUM_DIGITS];

  logic [7:0]            sseg_reg, sseg_next;
  logic [NUM_DIGITS-1:0] anode_reg, anode_next;
  logic                  frame_tick_reg;

  // Scan timing
  assign adv  = (prescaler_reg == PRE_LAST);
  assign wrap = adv && (digit_idx_reg == IDX_LAST);

  always_comb begin
    prescaler_next = adv ? '0 : prescaler_reg + 1'b1;
    digit_idx_next = digit_idx_reg;
    if (wrap) begin
      digit_idx_next = '0;
    end else if (adv) begin
      digit_idx_next = digit_idx_reg + 1'b1;
    end
  end

  // Double buffer: a Load coinciding with the wrap bypasses the shadow stage
  assign port_word = {HexIn, DPIn, DigitEn};

  always_comb begin
    shadow_next  = shadow_reg;
    active_next  = active_reg;
    pending_next = pending_reg;
    if (Load) begin
      shadow_next = port_word;
      if (wrap) begin
        active_next  = port_word;
        pending_next = 1'b0;
      end else begin
        pending_next = 1'b1;
      end
    end else if (wrap && pending_reg) begin
      active_next  = shadow_reg;
      pending_next = 1'b0;
    end
  end

  assign act_hex = active_reg[BW-1 -: 4*NUM_DIGITS];
  assign act_dp  = active_reg[2*NUM_DIGITS-1 -: NUM_DIGITS];
  assign act_en  = active_reg[NUM_DIGITS-1:0];

`ifdef SSEG_LEADING_ZERO_BLANK_EN
  // Walk down from the most significant digit while everything above is dark
  always_comb begin
    logic clear_above;
    blank       = '0;
    clear_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      blank[i]    = clear_above && (act_hex[4*i +: 4] == 4'h0) && !act_dp[i];
      clear_above = clear_above && (!act_en[i] || blank[i]);
    end
  end
`else
  assign blank = '0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign glyph_arr[gi] = glyph(act_hex[4*gi +: 4]);
      assign show[gi]      = act_en[gi] && !blank[gi];
    end
  endgenerate

  // Output mux uses the pre-edge digit index, so outputs trail it by one cycle
  always_comb begin
    sseg_next  = 8'hFF;
    anode_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((digit_idx_reg == IW'(i)) && show[i]) begin
        sseg_next  = {glyph_arr[i], ~act_dp[i]};
        anode_next = ~(NUM_DIGITS'(1) << i);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prescaler_reg  <= '0;
      digit_idx_reg  <= '0;
      shadow_reg     <= '0;
      active_reg     <= '0;
      pending_reg    <= 1'b0;
      sseg_reg       <= 8'hFF;
      anode_reg      <= '1;
      frame_tick_reg <= 1'b0;
    end else begin
      prescaler_reg  <= prescaler_next;
      digit_idx_reg  <= digit_idx_next;
      shadow_reg     <= shadow_next;
      active_reg     <= active_next;
      pending_reg    <= pending_next;
      sseg_reg       <= sseg_next;
      anode_reg      <= anode_next;
      frame_tick_reg <= wrap;
    end
  end

  assign SSeg      = sseg_reg;
  assign Anode     = anode_reg;
  assign FrameTick = frame_tick_reg;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Randomized bench for sseg_scan_driver against a cycle-count based display model.
module tb_sseg_scan_driver;
  localparam int N = 4;
  localparam int S = 4;
  localparam int F = N * S;

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic [15:0]  HexIn = '0;
  logic [3:0]   DPIn = '0;
  logic [3:0]   DigitEn = '0;
  logic         Load = 1'b0;
  logic [7:0]   SSeg;
  logic [3:0]   Anode;
  logic         FrameTick;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] glyph_tb [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  // Model state: edges since reset release plus the two data buffers
  int          cyc_cnt;
  logic [15:0] m_sh_hex, m_act_hex;
  logic [3:0]  m_sh_dp, m_act_dp, m_sh_en, m_act_en;
  bit          m_pend;
  logic [3:0]  exp_anode;
  logic [7:0]  exp_sseg;
  logic        exp_ft;

  always #5 Clk = ~Clk;

  sseg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S)) dut (
    .Clk(Clk), .Reset(Reset), .HexIn(HexIn), .DPIn(DPIn), .DigitEn(DigitEn),
    .Load(Load), .SSeg(SSeg), .Anode(Anode), .FrameTick(FrameTick)
  );

  function automatic bit lit(int i);
    if (!m_act_en[i]) return 1'b0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    if (i > 0 && m_act_hex[4*i +: 4] == 4'h0 && !m_act_dp[i]) begin
      bit all_hi;
      all_hi = 1'b1;
      for (int j = i + 1; j < N; j++)
        if (m_act_en[j] && !(m_act_hex[4*j +: 4] == 4'h0 && !m_act_dp[j])) all_hi = 1'b0;
      if (all_hi) return 1'b0;
    end
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    cyc_cnt = 0;
    m_sh_hex = '0; m_sh_dp = '0; m_sh_en = '0;
    m_act_hex = '0; m_act_dp = '0; m_act_en = '0;
    m_pend = 1'b0;
    exp_anode = 4'hF; exp_sseg = 8'hFF; exp_ft = 1'b0;
  endtask

  // One clock edge: update the model from the pre-edge state, then settle
  task automatic cyc();
    int idx;
    bit wrap;
    @(posedge Clk);
    if (Reset) begin
      model_reset();
    end else begin
      idx  = (cyc_cnt / S) % N;
      wrap = (cyc_cnt % F) == F - 1;
      if (lit(idx)) begin
        exp_anode = ~(4'b0001 << idx);
        exp_sseg  = {glyph_tb[m_act_hex[4*idx +: 4]], ~m_act_dp[idx]};
      end else begin
        exp_anode = 4'hF;
        exp_sseg  = 8'hFF;
      end
      exp_ft = wrap;
      if (Load) begin
        m_sh_hex = HexIn; m_sh_dp = DPIn; m_sh_en = DigitEn;
        if (wrap) begin
          m_act_hex = HexIn; m_act_dp = DPIn; m_act_en = DigitEn;
          m_pend = 1'b0;
        end else begin
          m_pend = 1'b1;
        end
      end else if (wrap && m_pend) begin
        m_act_hex = m_sh_hex; m_act_dp = m_sh_dp; m_act_en = m_sh_en;
        m_pend = 1'b0;
      end
      cyc_cnt++;
    end
    #1;
  endtask

  task automatic test_reset();
    #1 Reset = 1'b1;
    #1;
    vectors++;
    if ({Anode, SSeg, FrameTick} !== {4'hF, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_init: got anode=%b sseg=%h ft=%b, expected 1111 ff 0", Anode, SSeg, FrameTick);
    end
    model_reset();
    repeat (2) cyc();
    #2 Reset = 1'b0;
    for (int k = 0; k < 23; k++) begin
      HexIn = 16'($urandom); DPIn = 4'($urandom); DigitEn = 4'($urandom);
      Load = ($urandom_range(0, 3) == 0);
      cyc();
    end
    Load = 1'b0;
    // Pulse reset between edges mid-scan; outputs must clear without a clock
    #2 Reset = 1'b1;
    #1;
    vectors++;
    if ({Anode, SSeg, FrameTick} !== {4'hF, 8'hFF, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async: got anode=%b sseg=%h ft=%b, expected 1111 ff 0", Anode, SSeg, FrameTick);
    end
    model_reset();
    repeat (2) cyc();
    vectors++;
    if ({Anode, SSeg, FrameTick, dut.pending_reg} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_held: got anode=%b sseg=%h ft=%b pend=%b, expected 1111 ff 0 0",
               Anode, SSeg, FrameTick, dut.pending_reg);
    end
    #2 Reset = 1'b0;
  endtask

  task automatic test_display();
    bit found;
    logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] es [4] = '{8'h71, 8'h11, 8'h25, 8'h9F};
    HexIn = 16'h12AF; DPIn = 4'b0000; DigitEn = 4'hF; Load = 1'b1;
    cyc();
    Load = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2 * F && !found; k++) begin
      cyc();
      vectors++;
      if ({Anode, SSeg, FrameTick} !== {exp_anode, exp_sseg, exp_ft}) begin
        miscompares++;
        $display("FAIL display_wait: got %b %h %b, expected %b %h %b", Anode, SSeg, FrameTick, exp_anode, exp_sseg, exp_ft);
      end
      if (FrameTick) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL display_frametick: got no FrameTick in %0d cycles, expected one", 2 * F);
    end
    for (int k = 1; k <= F; k++) begin
      cyc();
      vectors++;
      if ({Anode, SSeg, FrameTick} !== {exp_anode, exp_sseg, exp_ft}) begin
        miscompares++;
        $display("FAIL display_model: got %b %h %b, expected %b %h %b", Anode, SSeg, FrameTick, exp_anode, exp_sseg, exp_ft);
      end
      if (found && (k % S) == 1) begin
        vectors++;
        if ({Anode, SSeg} !== {ea[k / S], es[k / S]}) begin
          miscompares++;
          $display("FAIL display_digit%0d: got anode=%b sseg=%h, expected %b %h", k / S, Anode, SSeg, ea[k / S], es[k / S]);
        end
      end
    end
  endtask

  // Entered right after a FrameTick sample from test_display
  task automatic test_mid_frame_load();
    for (int k = 1; k <= 2 * F; k++) begin
      if (k == 6) begin HexIn = 16'h8888; Load = 1'b1; end
      cyc();
      Load = 1'b0;
      vectors++;
      if ({Anode, SSeg, FrameTick} !== {exp_anode, exp_sseg, exp_ft}) begin
        miscompares++;
        $display("FAIL midload_model: got %b %h %b, expected %b %h %b", Anode, SSeg, FrameTick, exp_anode, exp_sseg, exp_ft);
      end
      if (k == 9 || k == 13) begin
        vectors++;
        if (SSeg !== ((k == 9) ? 8'h25 : 8'h9F)) begin
          miscompares++;
          $display("FAIL midload_old k=%0d: got sseg=%h, expected old frame data", k, SSeg);
        end
      end
      if (k == 17 || k == 29) begin
        vectors++;
        if (SSeg !== 8'h01) begin
          miscompares++;
          $display("FAIL midload_new k=%0d: got sseg=%h, expected 01", k, SSeg);
        end
      end
    end
  endtask

  task automatic test_enable();
    bit found;
    HexIn = 16'($urandom); DPIn = 4'b0100; DigitEn = 4'b0101; Load = 1'b1;
    cyc();
    Load = 1'b0;
    found = 1'b0;
    for (int k = 0; k < F + 2 && !found; k++) begin
      cyc();
      if (FrameTick) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL enable_frametick: got no FrameTick, expected one");
    end
    for (int k = 1; k <= F; k++) begin
      cyc();
      vectors++;
      if ({Anode, SSeg, FrameTick} !== {exp_anode, exp_sseg, exp_ft}) begin
        miscompares++;
        $display("FAIL enable_model: got %b %h %b, expected %b %h %b", Anode, SSeg, FrameTick, exp_anode, exp_sseg, exp_ft);
      end
      if (k == 5 || k == 13) begin
        vectors++;
        if ({Anode, SSeg} !== {4'b1111, 8'hFF}) begin
          miscompares++;
          $display("FAIL enable_dark k=%0d: got anode=%b sseg=%h, expected 1111 ff", k, Anode, SSeg);
        end
      end
      if (k == 9) begin
        vectors++;
        if ({Anode, SSeg[0]} !== {4'b1011, 1'b0}) begin
          miscompares++;
          $display("FAIL enable_dp: got anode=%b dp=%b, expected 1011 0", Anode, SSeg[0]);
        end
      end
    end
  endtask

  task automatic test_wrap_load();
    logic [15:0] h;
    logic [3:0]  d;
    for (int k = 0; k < F && (cyc_cnt % F) != F - 1; k++) cyc();
    h = 16'($urandom); d = 4'($urandom);
    HexIn = h; DPIn = d; DigitEn = 4'hF; Load = 1'b1;
    cyc();
    Load = 1'b0;
    vectors++;
    if ({FrameTick, dut.pending_reg} !== 2'b10) begin
      miscompares++;
      $display("FAIL wrapload_tick: got ft=%b pend=%b, expected 1 0", FrameTick, dut.pending_reg);
    end
    cyc();
    vectors++;
    if ({Anode, SSeg} !== {4'b1110, glyph_tb[h[3:0]], ~d[0]}) begin
      miscompares++;
      $display("FAIL wrapload_digit0: got anode=%b sseg=%h, expected 1110 %h", Anode, SSeg, {glyph_tb[h[3:0]], ~d[0]});
    end
    for (int k = 0; k < F; k++) begin
      cyc();
      vectors++;
      if ({Anode, SSeg, FrameTick} !== {exp_anode, exp_sseg, exp_ft}) begin
        miscompares++;
        $display("FAIL wrapload_model: got %b %h %b, expected %b %h %b", Anode, SSeg, FrameTick, exp_anode, exp_sseg, exp_ft);
      end
    end
  endtask

  task automatic test_blank();
    bit found;
    logic [11:0] want [4];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    want = '{{4'b1110, 8'h03}, {4'b1101, 8'h49}, {4'b1111, 8'hFF}, {4'b1111, 8'hFF}};
`else
    want = '{{4'b1110, 8'h03}, {4'b1101, 8'h49}, {4'b1011, 8'h03}, {4'b0111, 8'h03}};
`endif
    HexIn = 16'h0050; DPIn = 4'b0000; DigitEn = 4'hF; Load = 1'b1;
    cyc();
    Load = 1'b0;
    found = 1'b0;
    for (int k = 0; k < F + 2 && !found; k++) begin
      cyc();
      if (FrameTick) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL blank_frametick: got no FrameTick, expected one");
    end
    for (int k = 1; k <= F; k++) begin
      cyc();
      vectors++;
      if ({Anode, SSeg, FrameTick} !== {exp_anode, exp_sseg, exp_ft}) begin
        miscompares++;
        $display("FAIL blank_model: got %b %h %b, expected %b %h %b", Anode, SSeg, FrameTick, exp_anode, exp_sseg, exp_ft);
      end
      if ((k % S) == 1) begin
        vectors++;
        if ({Anode, SSeg} !== want[k / S]) begin
          miscompares++;
          $display("FAIL blank_digit%0d: got anode=%b sseg=%h, expected %h", k / S, Anode, SSeg, want[k / S]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      HexIn = 16'($urandom);
      DPIn = 4'($urandom);
      DigitEn = 4'($urandom);
      if ($urandom_range(0, 2) == 0) HexIn[15:8] = 8'h00;
      Load = ($urandom_range(0, 7) == 0);
      cyc();
      Load = 1'b0;
      vectors++;
      if ({Anode, SSeg, FrameTick} !== {exp_anode, exp_sseg, exp_ft}) begin
        miscompares++;
        $display("FAIL random_model cyc=%0d: got %b %h %b, expected %b %h %b",
                 k, Anode, SSeg, FrameTick, exp_anode, exp_sseg, exp_ft);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_display();
    test_mid_frame_load();
    test_enable();
    test_wrap_load();
    test_blank();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
